// File: rtl/count_wrap_monitor_pkg.sv
// Shared types and default widths for the count_wrap_monitor block.
package count_wrap_monitor_pkg;

  // Monitor FSM: INIT waits out a counter reset, TRACK performs transition checks.
  typedef enum logic {
    INIT  = 1'b0,
    TRACK = 1'b1
  } state_t;

  localparam int CNT_W_DEF  = 4;
  localparam int WRAP_W_DEF = 8;

endpackage : count_wrap_monitor_pkg

// File: rtl/count_wrap_monitor_if.sv
// Bundle of the observed counter signals plus the monitor's event/status outputs.
// master = side that drives the counter view (counter/bench); slave = the monitor.
interface count_wrap_monitor_if
  import count_wrap_monitor_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int WRAP_W = WRAP_W_DEF
) ();

  // Observed counter side
  logic              cnt_rst;
  logic [CNT_W-1:0]  count;
  logic              up_down;
  logic              load;
  logic              clr;

  // Monitor results
  logic              wrap_up;
  logic              wrap_dn;
  logic              step_err;
  logic [WRAP_W-1:0] wrap_cnt;
  logic              wrap_sat;
  logic              err_seen;
  logic              tracking;

  modport master (
    output cnt_rst, count, up_down, load, clr,
    input  wrap_up, wrap_dn, step_err, wrap_cnt, wrap_sat, err_seen, tracking
  );

  modport slave (
    input  cnt_rst, count, up_down, load, clr,
    output wrap_up, wrap_dn, step_err, wrap_cnt, wrap_sat, err_seen, tracking
  );

endinterface : count_wrap_monitor_if

// File: rtl/count_wrap_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment)
// and a sat flag that is high whenever the count sits at all-ones.
module count_wrap_monitor_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         sat
);

  logic [W-1:0] cnt_nxt;

  // Next count: clear, else increment unless already at all-ones.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cnt_nxt = cnt;
    if (clr) begin
      cnt_nxt = '0;
    end else if (inc && (cnt != '1)) begin
      cnt_nxt = cnt + W'(1);
    end
  end

  // Count and saturation flag registers; sat tracks the value being loaded so it
  // rises on the same edge the count becomes all-ones and drops only on clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sat <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      cnt <= cnt_nxt;
      sat <= &cnt_nxt;
    end
  end

endmodule : count_wrap_monitor_sat_counter

// File: rtl/count_wrap_monitor.sv
// Checker/statistics stage on a 4-bit up/down/load counter. Samples the counter
// every edge, compares the present count with the previous one under the
// controls that produced it, and emits registered wrap/error pulses plus a
// saturating wrap tally and sticky flags.
module count_wrap_monitor
  import count_wrap_monitor_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int WRAP_W = WRAP_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  count_wrap_monitor_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;

  // Previous-edge samples of the counter and the controls that act on it.
  logic [CNT_W-1:0] cnt_q;
  logic             dir_q;
  logic             ld_q;
  logic             rst_q;

  logic [CNT_W-1:0] expected;
  logic             check_en;
  logic             wrap_up_d, wrap_dn_d, step_err_d;

  logic             wrap_up_q, wrap_dn_q, step_err_q, err_seen_q;

  // Counter view registered every edge; independent of clr and the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      dir_q <= 1'b0;
      ld_q  <= 1'b0;
      rst_q <= 1'b0;
    end else begin
      cnt_q <= bus.count;
      dir_q <= bus.up_down;
      ld_q  <= bus.load;
      rst_q <= bus.cnt_rst;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: arm on the first edge out of counter reset, disarm on any counter reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (!bus.cnt_rst) state_d = TRACK;
      TRACK:   if (bus.cnt_rst)  state_d = INIT;
      default: state_d = INIT;
    endcase
  end

  // Transition check: a step is only judged in TRACK and when the previous
  // edge neither reset nor loaded the counter (load to same value included).
  always_comb begin
    expected   = dir_q ? (cnt_q + CNT_W'(1)) : (cnt_q - CNT_W'(1));
    check_en   = (state_q == TRACK) && !rst_q && !ld_q;
    wrap_up_d  = check_en &&  dir_q && (cnt_q == CNT_MAX) && (bus.count == '0);
    wrap_dn_d  = check_en && !dir_q && (cnt_q == '0)      && (bus.count == CNT_MAX);
    step_err_d = check_en && (bus.count != expected);
  end

  // Event pulses and sticky error flag; clr wins over a same-edge error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_up_q  <= 1'b0;
      wrap_dn_q  <= 1'b0;
      step_err_q <= 1'b0;
      err_seen_q <= 1'b0;
    end else begin
      wrap_up_q  <= wrap_up_d;
      wrap_dn_q  <= wrap_dn_d;
      step_err_q <= step_err_d;
      err_seen_q <= bus.clr ? 1'b0 : (err_seen_q | step_err_d);
    end
  end

  count_wrap_monitor_sat_counter #(
    .W (WRAP_W)
  ) u_sat_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (wrap_up_d | wrap_dn_d),
    .clr   (bus.clr),
    .cnt   (bus.wrap_cnt),
    .sat   (bus.wrap_sat)
  );

  assign bus.wrap_up  = wrap_up_q;
  assign bus.wrap_dn  = wrap_dn_q;
  assign bus.step_err = step_err_q;
  assign bus.err_seen = err_seen_q;
  assign bus.tracking = (state_q == TRACK);

endmodule : count_wrap_monitor

// File: tb/tb_count_wrap_monitor.sv
// Bench for count_wrap_monitor: emulates the counter, runs a default-width
// instance and a WRAP_W = 2 instance on the same stimulus, and scores both
// against a behavioural model through an expected-result queue.
module tb_count_wrap_monitor;
  import count_wrap_monitor_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  count_wrap_monitor_if #(.CNT_W(4), .WRAP_W(8)) bus_a ();
  count_wrap_monitor_if #(.CNT_W(4), .WRAP_W(2)) bus_b ();

  count_wrap_monitor #(.CNT_W(4), .WRAP_W(8)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  count_wrap_monitor #(.CNT_W(4), .WRAP_W(2)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  typedef struct packed {
    logic       wu;
    logic       wd;
    logic       se;
    logic [7:0] wc;
    logic       ws;
    logic       es;
    logic       trk;
    logic [1:0] wc2;
    logic       ws2;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Emulated counter value to present next.
  logic [3:0] ctr = 4'd0;

  // Model state
  logic [3:0] m_cnt;
  logic       m_dir, m_ld, m_rst, m_trk;
  logic [7:0] m_wc;
  logic [1:0] m_wc2;
  logic       m_ws, m_ws2, m_es;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = '0; m_dir = 1'b0; m_ld = 1'b0; m_rst = 1'b0; m_trk = 1'b0;
    m_wc = '0; m_wc2 = '0; m_ws = 1'b0; m_ws2 = 1'b0; m_es = 1'b0;
    ctr = '0;
  endtask

  // Predict the outputs after the coming edge and queue them.
  task automatic model_step(input logic [3:0] c, input logic ud, input logic ld,
                            input logic crst, input logic clr_i);
    exp_t       e;
    logic [3:0] ex_v;
    logic       chk, wu, wd, se;
    ex_v = m_dir ? 4'(m_cnt + 4'd1) : 4'(m_cnt - 4'd1);
    chk  = m_trk && !m_rst && !m_ld;
    wu   = chk &&  m_dir && (m_cnt == 4'hF) && (c == 4'h0);
    wd   = chk && !m_dir && (m_cnt == 4'h0) && (c == 4'hF);
    se   = chk && (c != ex_v);
    if (clr_i) begin
      m_wc = '0; m_wc2 = '0; m_ws = 1'b0; m_ws2 = 1'b0; m_es = 1'b0;
    end else begin
      if ((wu || wd) && (m_wc  != 8'hFF)) m_wc  = m_wc + 8'd1;
      if ((wu || wd) && (m_wc2 != 2'b11)) m_wc2 = m_wc2 + 2'd1;
      if (m_wc  == 8'hFF) m_ws  = 1'b1;
      if (m_wc2 == 2'b11) m_ws2 = 1'b1;
      if (se) m_es = 1'b1;
    end
    m_trk = !crst;
    m_cnt = c; m_dir = ud; m_ld = ld; m_rst = crst;
    e.wu = wu; e.wd = wd; e.se = se; e.wc = m_wc; e.ws = m_ws; e.es = m_es;
    e.trk = m_trk; e.wc2 = m_wc2; e.ws2 = m_ws2;
    sb_q.push_back(e);
  endtask

  task automatic compare_outputs();
    exp_t e;
    e = sb_q.pop_front();
    check("wrap_up",    bus_a.wrap_up,  e.wu);
    check("wrap_dn",    bus_a.wrap_dn,  e.wd);
    check("step_err",   bus_a.step_err, e.se);
    check("wrap_cnt",   bus_a.wrap_cnt, e.wc);
    check("wrap_sat",   bus_a.wrap_sat, e.ws);
    check("err_seen",   bus_a.err_seen, e.es);
    check("tracking",   bus_a.tracking, e.trk);
    check("w2_wrap_cnt", bus_b.wrap_cnt, e.wc2);
    check("w2_wrap_sat", bus_b.wrap_sat, e.ws2);
  endtask

  task automatic set_inputs(input logic [3:0] c, input logic ud, input logic ld,
                            input logic crst, input logic clr_i);
    bus_a.count = c; bus_a.up_down = ud; bus_a.load = ld; bus_a.cnt_rst = crst; bus_a.clr = clr_i;
    bus_b.count = c; bus_b.up_down = ud; bus_b.load = ld; bus_b.cnt_rst = crst; bus_b.clr = clr_i;
  endtask

  // One clock: present inputs (called at negedge), score just after posedge,
  // advance the emulated counter, return at the next negedge.
  task automatic cycle(input logic [3:0] c, input logic ud, input logic ld,
                       input logic [3:0] ld_val, input logic clr_i, input logic crst);
    set_inputs(c, ud, ld, crst, clr_i);
    model_step(c, ud, ld, crst, clr_i);
    @(posedge clk);
    #1;
    compare_outputs();
    if (crst)    ctr = 4'd0;
    else if (ld) ctr = ld_val;
    else         ctr = ud ? 4'(c + 4'd1) : 4'(c - 4'd1);
    @(negedge clk);
  endtask

  task automatic step(input logic ud, input logic ld = 1'b0, input logic [3:0] ld_val = 4'd0,
                      input logic clr_i = 1'b0, input logic crst = 1'b0);
    cycle(ctr, ud, ld, ld_val, clr_i, crst);
  endtask

  // Load 15, count up once to present 15, then present 0 (the wrap edge).
  task automatic up_wrap(input logic clr_last);
    step(1'b1, 1'b1, 4'hF);
    step(1'b1);
    step(1'b1, 1'b0, 4'd0, clr_last);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wrap_up"},  bus_a.wrap_up,  0);
    check({tag, "_wrap_dn"},  bus_a.wrap_dn,  0);
    check({tag, "_step_err"}, bus_a.step_err, 0);
    check({tag, "_wrap_cnt"}, bus_a.wrap_cnt, 0);
    check({tag, "_wrap_sat"}, bus_a.wrap_sat, 0);
    check({tag, "_err_seen"}, bus_a.err_seen, 0);
    check({tag, "_tracking"}, bus_a.tracking, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    set_inputs(4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    #12;
    check_all_zero("init_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Counter held in reset, then released; the monitor arms on the release edge.
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    step(1'b1);
    step(1'b1);

    // Up wrap: load 13, count 13, 14, 15, 0, 1.
    step(1'b1, 1'b1, 4'd13);
    repeat (5) step(1'b1);
    check("up_wrap_total", bus_a.wrap_cnt, 1);
    check("up_wrap_no_err", bus_a.err_seen, 0);

    // Down wrap, then direction change at 14 -> 15.
    step(1'b0, 1'b1, 4'd2);
    repeat (4) step(1'b0);
    step(1'b1);
    step(1'b1);
    check("dn_wrap_total", bus_a.wrap_cnt, 2);
    check("dn_wrap_no_err", bus_a.err_seen, 0);

    // Load 3 from 9 is exempt; holding 3 for a cycle is an error.
    step(1'b1, 1'b1, 4'd9);
    step(1'b1, 1'b1, 4'd3);
    check("load_exempt", bus_a.err_seen, 0);
    cycle(4'd3, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    cycle(4'd3, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    check("hold_err_pulse", bus_a.step_err, 1);
    repeat (3) step(1'b1);
    check("err_sticky", bus_a.err_seen, 1);

    // Clear, then five up-wraps: narrow tally saturates at 3.
    step(1'b1, 1'b0, 4'd0, 1'b1);
    check("clr_err", bus_a.err_seen, 0);
    repeat (5) up_wrap(1'b0);
    check("sat_narrow_cnt", bus_b.wrap_cnt, 3);
    check("sat_narrow_flag", bus_b.wrap_sat, 1);
    check("sat_wide_cnt", bus_a.wrap_cnt, 5);

    // clr colliding with a wrap edge: pulse fires, tally stays cleared.
    step(1'b1, 1'b0, 4'd0, 1'b1);
    up_wrap(1'b0);
    up_wrap(1'b0);
    check("pre_clr_cnt", bus_a.wrap_cnt, 2);
    up_wrap(1'b1);
    check("clr_coll_pulse", bus_a.wrap_up, 1);
    check("clr_coll_cnt", bus_a.wrap_cnt, 0);
    check("clr_coll_sat", bus_b.wrap_sat, 0);

    // Asynchronous reset mid-run with wrap_cnt = 5.
    repeat (5) up_wrap(1'b0);
    check("pre_rst_cnt", bus_a.wrap_cnt, 5);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    check("rearm_wait", bus_a.tracking, 0);
    step(1'b1);
    check("rearm_track", bus_a.tracking, 1);
    repeat (3) step(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_count_wrap_monitor
